// File: rtl/fifo_pkg.sv
// Shared FIFO geometry, pointer-sync FSM states and fill-level arithmetic
// used by both the write-side and read-side pointer units.
package fifo_pkg;

  localparam int FIFO_S     = 8;
  localparam int FIFO_DEPTH = 90;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CAPT   = 2'd1,
    ST_COMMIT = 2'd2
  } sync_state_e;

  // Occupancy from pointer indices; on differing wrap bits the writer is one lap ahead.
  function automatic int unsigned fill_calc(input int unsigned wi,
                                            input int unsigned ri,
                                            input logic        same_wrap,
                                            input int unsigned depth);
    return same_wrap ? (wi - ri) : (depth - ri + wi);
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop single-bit synchronizer with asynchronous active-high clear.
module cdc_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_ff <= '0;
    else     sync_ff <= {sync_ff[SYNC_STAGES-2:0], d};
  end

  assign q = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/rd_ptr_sync_wr.sv
// Write-domain receiver of the read pointer via a toggle handshake; commits
// only plausible pointers and derives registered fill level / almost-full.
module rd_ptr_sync_wr
  import fifo_pkg::*;
#(
  parameter int S           = FIFO_S,
  parameter int DEPTH       = FIFO_DEPTH,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 4
) (
  input  logic         wr_clk,
  input  logic         wr_rst,
  input  logic         rd_req_tgl,
  input  logic [S-1:0] rd_ptr_hold,
  input  logic [S-1:0] wr_ptr,
  output logic         rd_ack_tgl,
  output logic [S-1:0] rd_ptr_sync,
  output logic [S-1:0] fill_level,
  output logic         almost_full,
  output logic         ptr_err
);

  localparam logic [S-1:0] DEPTH_S  = S'(DEPTH);
  localparam logic [S-1:0] AF_LEVEL = S'(DEPTH - AF_THRESH);

  logic        req_s;
  logic        req_seen;
  sync_state_e state;
  logic [S-1:0] raw;
  logic        raw_valid;
  logic [S-1:0] fill_next;

  cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .clk (wr_clk),
    .rst (wr_rst),
    .d   (rd_req_tgl),
    .q   (req_s)
  );

  // A read pointer may not point past the storage nor ahead of the writer.
  always_comb begin
    raw_valid = 1'b1;
    if ({1'b0, raw[S-2:0]} >= DEPTH_S)
      raw_valid = 1'b0;
    else if ((raw[S-1] == wr_ptr[S-1]) && (raw[S-2:0] > wr_ptr[S-2:0]))
      raw_valid = 1'b0;
    else if ((raw[S-1] != wr_ptr[S-1]) && (raw[S-2:0] < wr_ptr[S-2:0]))
      raw_valid = 1'b0;
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state       <= ST_IDLE;
      req_seen    <= 1'b0;
      raw         <= '0;
      rd_ptr_sync <= '0;
      rd_ack_tgl  <= 1'b0;
      ptr_err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_s != req_seen) begin
            raw      <= rd_ptr_hold;
            req_seen <= req_s;
            state    <= ST_CAPT;
          end
        end
        ST_CAPT: state <= ST_COMMIT;
        ST_COMMIT: begin
          if (raw_valid) rd_ptr_sync <= raw;
          else           ptr_err     <= 1'b1;
          // Always acknowledge so the read side never waits forever.
          rd_ack_tgl <= ~rd_ack_tgl;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    fill_next = S'(fill_calc(32'(wr_ptr[S-2:0]), 32'(rd_ptr_sync[S-2:0]),
                             wr_ptr[S-1] == rd_ptr_sync[S-1], DEPTH));
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      fill_level  <= '0;
      almost_full <= 1'b0;
    end else begin
      fill_level  <= fill_next;
      almost_full <= (fill_next >= AF_LEVEL);
    end
  end

endmodule

// File: tb/tb_rd_ptr_sync_wr.sv
// Directed bench for rd_ptr_sync_wr: table of transfers plus reset and
// overlapping-toggle sequences.
module tb_rd_ptr_sync_wr;

  localparam int S = 8;

  logic         wr_clk;
  logic         wr_rst;
  logic         rd_req_tgl;
  logic [S-1:0] rd_ptr_hold;
  logic [S-1:0] wr_ptr;
  logic         rd_ack_tgl;
  logic [S-1:0] rd_ptr_sync;
  logic [S-1:0] fill_level;
  logic         almost_full;
  logic         ptr_err;

  rd_ptr_sync_wr #(.S(S), .DEPTH(90), .SYNC_STAGES(2), .AF_THRESH(4)) dut (
    .wr_clk      (wr_clk),
    .wr_rst      (wr_rst),
    .rd_req_tgl  (rd_req_tgl),
    .rd_ptr_hold (rd_ptr_hold),
    .wr_ptr      (wr_ptr),
    .rd_ack_tgl  (rd_ack_tgl),
    .rd_ptr_sync (rd_ptr_sync),
    .fill_level  (fill_level),
    .almost_full (almost_full),
    .ptr_err     (ptr_err)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  typedef struct {
    logic         pre_reset;
    logic [S-1:0] wp;
    logic [S-1:0] hold;
    logic [S-1:0] exp_sync;
    logic [S-1:0] exp_fill;
    logic         exp_af;
    logic         exp_err;
  } vec_t;

  vec_t vecs[10];
  int   n_tests;
  int   n_fail;
  logic exp_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Mid-cycle reset pulse; outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    @(negedge wr_clk);
    #2 wr_rst = 1'b1;
    rd_req_tgl = 1'b0;
    #1;
    chk("rst_sync", rd_ptr_sync, 0);
    chk("rst_ack",  rd_ack_tgl,  0);
    chk("rst_fill", fill_level,  0);
    chk("rst_af",   almost_full, 0);
    chk("rst_err",  ptr_err,     0);
    @(negedge wr_clk);
    wr_rst  = 1'b0;
    exp_ack = 1'b0;
  endtask

  task automatic transfer(input int idx, input vec_t v);
    @(negedge wr_clk);
    wr_ptr      = v.wp;
    rd_ptr_hold = v.hold;
    rd_req_tgl  = ~rd_req_tgl;
    @(posedge wr_clk);                 // edge 0: first sample of new level
    repeat (3) @(posedge wr_clk);      // edge 3
    #1 chk($sformatf("v%0d_ack_early", idx), rd_ack_tgl, exp_ack);
    @(posedge wr_clk);                 // edge 4: commit
    #1;
    exp_ack = ~exp_ack;
    chk($sformatf("v%0d_ack", idx),  rd_ack_tgl,  exp_ack);
    chk($sformatf("v%0d_sync", idx), rd_ptr_sync, v.exp_sync);
    @(posedge wr_clk);                 // edge 5: fill reflects commit
    #1;
    chk($sformatf("v%0d_fill", idx), fill_level,  v.exp_fill);
    chk($sformatf("v%0d_af", idx),   almost_full, v.exp_af);
    chk($sformatf("v%0d_err", idx),  ptr_err,     v.exp_err);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_ack = 1'b0;
    wr_rst = 1'b1;
    rd_req_tgl = 1'b0;
    rd_ptr_hold = '0;
    wr_ptr = '0;

    //          rst   wp     hold   sync   fill   af    err
    vecs[0] = '{1'b0, 8'h0A, 8'h05, 8'h05, 8'd5,  1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h83, 8'h58, 8'h58, 8'd5,  1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h85, 8'h05, 8'h05, 8'd90, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h85, 8'h09, 8'h09, 8'd86, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h85, 8'h0A, 8'h0A, 8'd85, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h0A, 8'h5A, 8'h00, 8'd10, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 8'h0A, 8'h0B, 8'h00, 8'd10, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 8'h20, 8'h83, 8'h00, 8'd32, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 8'h20, 8'h20, 8'h20, 8'd0,  1'b0, 1'b0};
    vecs[9] = '{1'b0, 8'hA0, 8'h20, 8'h20, 8'd90, 1'b1, 1'b0};

    repeat (2) @(posedge wr_clk);
    @(negedge wr_clk);
    wr_rst = 1'b0;
    @(negedge wr_clk);
    chk("init_sync", rd_ptr_sync, 0);
    chk("init_ack",  rd_ack_tgl,  0);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].pre_reset) do_reset();
      transfer(i, vecs[i]);
    end

    // Reset while a transfer is in flight: nothing may commit afterwards.
    @(negedge wr_clk);
    wr_ptr      = 8'h0A;
    rd_ptr_hold = 8'h05;
    rd_req_tgl  = ~rd_req_tgl;
    @(posedge wr_clk);
    repeat (3) @(posedge wr_clk);
    #1 wr_rst = 1'b1;
    rd_req_tgl = 1'b0;
    #1;
    chk("mid_rst_sync", rd_ptr_sync, 0);
    chk("mid_rst_ack",  rd_ack_tgl,  0);
    @(negedge wr_clk);
    wr_rst  = 1'b0;
    exp_ack = 1'b0;
    repeat (8) @(posedge wr_clk);
    #1;
    chk("post_rst_sync", rd_ptr_sync, 0);
    chk("post_rst_ack",  rd_ack_tgl,  0);
    chk("post_rst_fill", fill_level,  8'd10);

    // Second toggle arrives while the first is still being processed.
    @(negedge wr_clk);
    wr_ptr      = 8'h0A;
    rd_ptr_hold = 8'h05;
    rd_req_tgl  = 1'b1;
    @(posedge wr_clk);                 // edge 0
    @(posedge wr_clk);                 // edge 1
    @(negedge wr_clk);
    rd_req_tgl = 1'b0;
    repeat (3) @(posedge wr_clk);      // edge 4: first commit
    #1;
    chk("ovl_ack1",  rd_ack_tgl,  1);
    chk("ovl_sync1", rd_ptr_sync, 8'h05);
    @(negedge wr_clk);
    rd_ptr_hold = 8'h07;
    for (int c = 0; c < 20 && rd_ack_tgl !== 1'b0; c++) @(posedge wr_clk);
    #1;
    chk("ovl_ack2",  rd_ack_tgl,  0);
    chk("ovl_sync2", rd_ptr_sync, 8'h07);
    chk("ovl_err",   ptr_err,     0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rd_ptr_sync_wr.md
RD_PTR_SYNC_WR -- requirements
Module: rd_ptr_sync_wr

Interface
REQ-001 Parameters SHALL be: S, 8, pointer width (MSB = wrap bit, S-1 LSBs = index); DEPTH, 90, FIFO entries (DEPTH <= 2^(S-1)); SYNC_STAGES, 2, synchronizer flops (>= 2); AF_THRESH, 4, almost-full margin.
REQ-002 Reset SHALL be wr_rst, asynchronous, active-high; clock SHALL be wr_clk.
REQ-003 Ports SHALL be:
- wr_clk  in  1  write-domain clock
- wr_rst  in  1  async active-high reset
- rd_req_tgl  in  1  request toggle from read domain (asynchronous)
- rd_ptr_hold  in  S  read pointer, held stable by sender until ack toggles
- wr_ptr  in  S  write pointer, wr_clk domain
- rd_ack_tgl  out  1  acknowledge toggle back to read domain
- rd_ptr_sync  out  S  committed read pointer, wr_clk domain
- fill_level  out  S  occupied entries, 0..DEPTH
- almost_full  out  1  fill_level >= DEPTH-AF_THRESH
- ptr_err  out  1  sticky invalid-pointer flag

Function
REQ-004 rd_req_tgl SHALL pass through a SYNC_STAGES-flop synchronizer; its output is req_s.
REQ-005 Register req_seen SHALL hold the last serviced toggle level; new request = (req_s != req_seen) in state IDLE.
REQ-006 FSM SHALL have states IDLE, CAPT, COMMIT; IDLE->CAPT on new request, CAPT->COMMIT unconditionally, COMMIT->IDLE unconditionally.
REQ-007 On IDLE->CAPT edge: raw <= rd_ptr_hold, req_seen <= req_s.
REQ-008 In COMMIT, raw SHALL be invalid if index >= DEPTH, or wrap bits equal to wr_ptr and raw index > wr_ptr index, or wrap bits differ and raw index < wr_ptr index.
REQ-009 On COMMIT->IDLE edge: valid raw -> rd_ptr_sync <= raw; invalid raw -> rd_ptr_sync unchanged, ptr_err <= 1.
REQ-010 rd_ack_tgl SHALL invert on every COMMIT->IDLE edge, valid or invalid (sender never deadlocks).
REQ-011 Latency: rd_ptr_sync and rd_ack_tgl SHALL update on wr_clk edge SYNC_STAGES+2 after the first edge sampling the new rd_req_tgl level.
REQ-012 fill_level SHALL be registered every cycle from wr_ptr and rd_ptr_sync: equal wrap bits -> wi-ri; differing -> DEPTH-ri+wi; one-cycle latency.
REQ-013 almost_full SHALL be registered together with fill_level from the same computed value.
REQ-014 A toggle arriving during CAPT/COMMIT (protocol violation) SHALL NOT be lost; it is serviced from the next IDLE.
REQ-015 ptr_err SHALL remain set until wr_rst.
REQ-016 Arithmetic SHALL be S-bit unsigned; DEPTH-ri+wi SHALL NOT overflow for DEPTH <= 2^(S-1).

Reset
REQ-017 wr_rst SHALL asynchronously clear synchronizer flops, req_seen, raw, rd_ptr_sync, rd_ack_tgl, fill_level, almost_full, ptr_err to 0 and force IDLE.
REQ-018 Reset mid-transfer SHALL abort without committing raw; the read domain SHALL be reset together (toggle levels restart at 0).
REQ-019 Behaviour SHALL resume on the first wr_clk edge after wr_rst deasserts.

Structure
REQ-020 Shared package fifo_pkg SHALL hold FIFO_S=8, FIFO_DEPTH=90, the FSM state typedef and the fill-level function, reused by the write and read units.
REQ-021 The synchronizer SHALL be one sub-module, cdc_sync_bit (parameter SYNC_STAGES), reused for the read-domain ack path.

Verification
REQ-022 Reset: pulse wr_rst mid-cycle -> all outputs 0 immediately, FSM IDLE.
REQ-023 Single transfer: wr_ptr=8'h0A, rd_ptr_hold=8'h05, rd_req_tgl 0->1 -> rd_ptr_sync=8'h05 and rd_ack_tgl=1 at edge 4; fill_level=5 at edge 5.
REQ-024 Wrap: wr_ptr=8'h83, rd_ptr_hold=8'h58 -> rd_ptr_sync=8'h58, fill_level=5, almost_full=0.
REQ-025 Full boundary: wr_ptr=8'h85, rd_ptr_hold=8'h05 -> fill_level=90, almost_full=1; then rd_ptr_hold=8'h09 -> fill_level=86, almost_full=1; rd_ptr_hold=8'h0A -> 85, almost_full=0.
REQ-026 Invalid: rd_ptr_hold=8'h5A (index 90) -> ptr_err=1, rd_ptr_sync unchanged, rd_ack_tgl still toggles.
REQ-027 Reset mid-transfer: toggle rd_req_tgl, assert wr_rst at edge 3 -> rd_ptr_sync=0, rd_ack_tgl=0, no commit after release.
